// File: rtl/winograd_tile_buffer_pkg.sv
// Shared constants, FSM encoding and tile packing helpers for the Winograd
// F(2x2,3x3) input-tile buffer. The packing helpers are the single source of
// truth for where pixel (r,c) lives inside a flattened 4x4 tile word.
package winograd_tile_buffer_pkg;

  localparam int OUT_N       = 2;                   // output tile edge
  localparam int FILT_N      = 3;                   // filter edge
  localparam int TILE_N      = OUT_N + FILT_N - 1;  // input tile edge (4)
  localparam int TILE_STRIDE = OUT_N;               // tile origin step (2)

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Element slot of pixel (r,c) in a [TILE_N*TILE_N-1:0][DW-1:0] tile; row 0
  // lands in the most significant slots.
  function automatic int tile_slot(input int r, input int c);
    return TILE_N*TILE_N - 1 - (TILE_N*r + c);
  endfunction

  // MSB bit position of pixel (r,c) in a flat TILE_N*TILE_N*dw tile word.
  function automatic int tile_msb(input int r, input int c, input int dw);
    return dw*(tile_slot(r, c) + 1) - 1;
  endfunction

endpackage

// File: rtl/winograd_tile_buffer_if.sv
// Pixel-in / tile-out stream bundle of the tile buffer.
//   in_valid/in_data/in_ready        : raster pixel stream, one DW pixel per beat
//   tile_valid/tile_data/tile_ready  : 4x4 tile stream, 16*DW bits per beat
//   tile_row/tile_col                : tile indices (origin = 2*index)
//   frame_done                       : one-cycle pulse after a frame's last tile
// slave = buffer side, master = feeder/consumer side.
interface winograd_tile_buffer_if #(
  parameter int DW = 8
);
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            tile_valid;
  logic [16*DW-1:0] tile_data;
  logic            tile_ready;
  logic [7:0]      tile_row;
  logic [7:0]      tile_col;
  logic            frame_done;

  modport master (
    output in_valid, in_data, tile_ready,
    input  in_ready, tile_valid, tile_data, tile_row, tile_col, frame_done
  );

  modport slave (
    input  in_valid, in_data, tile_ready,
    output in_ready, tile_valid, tile_data, tile_row, tile_col, frame_done
  );
endinterface

// File: rtl/winograd_tile_buffer_row_buf.sv
// 4-row x IMG_W pixel line store for the tile buffer.
//   clk                 : write clock
//   we/wr_row/wr_col/wr_data : single pixel write port (row = image row mod 4)
//   rd_row/rd_col       : buffer row holding the window's top row, window left col
//   rd_tile             : combinational 4x4 window, packed row 0 in MSB slots
// Contents are not reset; every location is written before it is read.
module winograd_tile_buffer_row_buf
  import winograd_tile_buffer_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int DW    = 8,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [1:0]                          wr_row,
  input  logic [CW-1:0]                       wr_col,
  input  logic [DW-1:0]                       wr_data,
  input  logic [1:0]                          rd_row,
  input  logic [CW-1:0]                       rd_col,
  output logic [TILE_N*TILE_N-1:0][DW-1:0]    rd_tile
);

  logic [TILE_N-1:0][IMG_W-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_row][wr_col] <= wr_data;
  end

  // Window rows wrap modulo 4 so the band can slide by two rows without
  // moving data; the two oldest rows are simply overwritten in place.
  for (genvar r = 0; r < TILE_N; r++) begin : g_r
    for (genvar c = 0; c < TILE_N; c++) begin : g_c
      localparam int SLOT = tile_slot(r, c);
      logic [1:0]    rr;
      logic [CW-1:0] cc;
      assign rr = rd_row + 2'(r);
      assign cc = rd_col + CW'(c);
      assign rd_tile[SLOT] = mem_q[rr][cc];
    end
  end

endmodule

// File: rtl/winograd_tile_buffer.sv
// Raster pixel stream -> overlapping 4x4 stride-2 tiles for a Winograd
// F(2x2,3x3) stage. Buffers a 4-row band, then emits the band's tiles one per
// handshake, then refills two rows for the next band.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : stream bundle (slave side), see winograd_tile_buffer_if
// Fill and emit are mutually exclusive: in_ready is low for the whole
// LOAD/EMIT span.
module winograd_tile_buffer
  import winograd_tile_buffer_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  winograd_tile_buffer_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int TX = IMG_W/TILE_STRIDE - 1;   // tiles per band
  localparam int TY = IMG_H/TILE_STRIDE - 1;   // bands per frame
  localparam int TW = TILE_N*TILE_N*DW;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            tile_valid_q, tile_valid_d;
  logic [TW-1:0]   tile_data_q, tile_data_d;
  logic [7:0]      ty_q, ty_d;
  logic [7:0]      tx_q, tx_d;
  logic            frame_done_q, frame_done_d;
  logic [CW-1:0]   col_q, col_d;      // write column
  logic [1:0]      wrow_q, wrow_d;    // write row = image row mod 4
  logic [1:0]      rcnt_q, rcnt_d;    // rows completed in current band

  logic            wr_en;
  logic [7:0]      rd_tx;
  logic [1:0]      rd_row;
  logic [CW-1:0]   rd_col;
  logic [TILE_N*TILE_N-1:0][DW-1:0] win;

  // Window top row is image row 2*ty, i.e. buffer row (2*ty) mod 4.
  assign rd_row = {ty_q[0], 1'b0};
  assign rd_col = CW'({rd_tx, 1'b0});

  winograd_tile_buffer_row_buf #(
    .IMG_W (IMG_W),
    .DW    (DW),
    .CW    (CW)
  ) u_row_buf (
    .clk     (clk),
    .we      (wr_en),
    .wr_row  (wrow_q),
    .wr_col  (col_q),
    .wr_data (bus.in_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_tile (win)
  );

  always_comb begin
    state_d      = state_q;
    tile_valid_d = tile_valid_q;
    tile_data_d  = tile_data_q;
    ty_d         = ty_q;
    tx_d         = tx_q;
    col_d        = col_q;
    wrow_d       = wrow_q;
    rcnt_d       = rcnt_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    rd_tx        = tx_q;

    unique case (state_q)
      ST_FILL: begin
        if (bus.in_valid && in_ready_q) begin
          wr_en = 1'b1;
          if (col_q == CW'(IMG_W-1)) begin
            col_d  = '0;
            wrow_d = wrow_q + 2'd1;
            // First band of a frame (ty==0) needs 4 rows, later bands 2.
            if (rcnt_q == ((ty_q == 8'd0) ? 2'd3 : 2'd1)) begin
              rcnt_d  = 2'd0;
              state_d = ST_LOAD;
            end else begin
              rcnt_d = rcnt_q + 2'd1;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      ST_LOAD: begin
        rd_tx        = 8'd0;
        tile_data_d  = win;
        tile_valid_d = 1'b1;
        tx_d         = 8'd0;
        state_d      = ST_EMIT;
      end

      ST_EMIT: begin
        if (bus.tile_ready) begin
          if (tx_q != 8'(TX-1)) begin
            // Preload the next tile on the handshake edge: 1 tile/cycle.
            rd_tx       = tx_q + 8'd1;
            tx_d        = tx_q + 8'd1;
            tile_data_d = win;
          end else begin
            tile_valid_d = 1'b0;
            tx_d         = 8'd0;
            state_d      = ST_FILL;
            if (ty_q != 8'(TY-1)) begin
              ty_d = ty_q + 8'd1;
            end else begin
              ty_d         = 8'd0;
              wrow_d       = 2'd0;  // next frame restarts at buffer row 0
              frame_done_d = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_FILL;
    endcase

    in_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_FILL;
      in_ready_q   <= 1'b0;
      tile_valid_q <= 1'b0;
      tile_data_q  <= '0;
      ty_q         <= 8'd0;
      tx_q         <= 8'd0;
      frame_done_q <= 1'b0;
      col_q        <= '0;
      wrow_q       <= 2'd0;
      rcnt_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      tile_valid_q <= tile_valid_d;
      tile_data_q  <= tile_data_d;
      ty_q         <= ty_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      wrow_q       <= wrow_d;
      rcnt_q       <= rcnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.tile_valid = tile_valid_q;
  assign bus.tile_data  = tile_data_q;
  assign bus.tile_row   = ty_q;
  assign bus.tile_col   = tx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_winograd_tile_buffer.sv
// Bench for winograd_tile_buffer: a 4x4 instance for the single-tile case and
// an 8x8 instance checked every cycle against a frame-level tile model.
module tb_winograd_tile_buffer;

  localparam int W = 8, H = 8, TXN = 3, NT = 9;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  winograd_tile_buffer_if #(.DW(8)) bus8 ();
  winograd_tile_buffer_if #(.DW(8)) bus4 ();

  winograd_tile_buffer #(.IMG_W(8), .IMG_H(8), .DW(8)) dut8 (
    .clk(clk), .rstn(rstn), .bus(bus8.slave));
  winograd_tile_buffer #(.IMG_W(4), .IMG_H(4), .DW(8)) dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4.slave));

  int checks = 0, failures = 0;
  int pat_add = 0;
  int exp_idx = 0, frames8 = 0, cyc = 0, last_band_cyc = -100, acc = 0;
  int ety, etx, stall_obs = 0;
  bit fd_exp = 0, fd_next;
  bit cap_en = 0;
  logic [127:0] got [NT];
  bit prev_valid = 0, prev_ready = 0;
  logic [127:0] prev_data;
  logic [15:0]  prev_rc;
  bit stall_req = 0, stalling = 0, rdy_def = 1, abort = 0, send_busy = 0;
  int stall_at = 4, stall_len = 5;

  task automatic check(input string nm, input logic [127:0] g, input logic [127:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, e);
    end
  endtask

  // Frame model: pixel value by position, tile by origin.
  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(8*r + c + pat_add);
  endfunction

  function automatic logic [127:0] exp_tile(input int ty, input int tx);
    logic [127:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[127-8*(4*r+c) -: 8] = pix(2*ty + r, 2*tx + c);
    return v;
  endfunction

  // Compare process for the 8x8 instance.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        check("reset_ctrl", 128'({bus8.in_ready, bus8.tile_valid, bus8.frame_done,
                                  bus8.tile_row, bus8.tile_col}), '0);
        check("reset_data", bus8.tile_data, '0);
        exp_idx = 0; acc = 0; fd_exp = 0; prev_valid = 0; prev_ready = 0;
        continue;
      end
      fd_next = 0;
      check("frame_done", 128'(bus8.frame_done), 128'(fd_exp));
      if (bus8.frame_done) frames8++;
      if (bus8.tile_valid) begin
        ety = exp_idx / TXN;
        etx = exp_idx % TXN;
        check("in_ready_during_emit", 128'(bus8.in_ready), '0);
        check("tile_data", bus8.tile_data, exp_tile(ety, etx));
        check("tile_row_col", 128'({bus8.tile_row, bus8.tile_col}), 128'({8'(ety), 8'(etx)}));
        if (prev_valid && !prev_ready) begin
          check("stall_hold_data", bus8.tile_data, prev_data);
          check("stall_hold_rc", 128'({bus8.tile_row, bus8.tile_col}), 128'(prev_rc));
        end
        if (!prev_valid) check("valid_latency", 128'(cyc - last_band_cyc), 128'(2));
        if (bus8.tile_ready) begin
          if (cap_en) got[exp_idx] = bus8.tile_data;
          exp_idx++;
          if (exp_idx == NT) begin exp_idx = 0; fd_next = 1; end
        end else begin
          stall_obs++;
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        if ((acc % W == W-1) && ((acc / W == 3) || ((acc / W > 3) && ((acc / W) % 2 == 1))))
          last_band_cyc = cyc;
        acc++;
        if (acc == W*H) acc = 0;
      end
      prev_valid = bus8.tile_valid;
      prev_ready = bus8.tile_ready;
      prev_data  = bus8.tile_data;
      prev_rc    = {bus8.tile_row, bus8.tile_col};
      fd_exp     = fd_next;
    end
  end

  // tile_ready driver with an optional one-shot stall at tile index stall_at.
  initial begin
    bus8.tile_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_req && bus8.tile_valid && exp_idx == stall_at) begin
        stalling = 1; stall_req = 0;
        bus8.tile_ready = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1 bus8.tile_ready = 1'b1;
        stalling = 0;
      end else begin
        bus8.tile_ready = rdy_def;
      end
    end
  end

  task automatic send_frame(input bit gap);
    int p = 0, budget = 0;
    bit v;
    send_busy = 1;
    while (p < W*H && !abort) begin
      @(posedge clk); #1;
      v = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      bus8.in_valid = v;
      bus8.in_data  = v ? pix(p / W, p % W) : 8'($urandom);
      @(negedge clk);
      if (bus8.in_valid && bus8.in_ready) p++;
      budget++;
      if (budget > 4000) begin
        check("send_timeout", 128'(p), 128'(W*H));
        break;
      end
    end
    @(posedge clk); #1 bus8.in_valid = 1'b0;
    send_busy = 0;
  endtask

  task automatic wait_frames(input int n);
    int b = 0;
    while (frames8 < n && b < 3000) begin @(negedge clk); b++; end
    check("frame_count", 128'(frames8), 128'(n));
  endtask

  task automatic wait_flag(input string nm, input bit want, input int which);
    int b = 0;
    bit cur;
    cur = (which == 0) ? stalling : send_busy;
    while (cur != want && b < 3000) begin
      @(negedge clk); b++;
      cur = (which == 0) ? stalling : send_busy;
    end
    check(nm, 128'(cur), 128'(want));
  endtask

  initial begin
    int p, b;
    // Scenario 1: reset with in_valid asserted.
    rstn = 1'b0;
    bus8.in_valid = 1'b1; bus8.in_data = 8'h55;
    bus4.in_valid = 1'b1; bus4.in_data = 8'h55; bus4.tile_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("s1_in_ready8", 128'(bus8.in_ready), '0);
      check("s1_tile_valid8", 128'(bus8.tile_valid), '0);
      check("s1_in_ready4", 128'(bus4.in_ready), '0);
      check("s1_out4", 128'({bus4.tile_valid, bus4.frame_done}), '0);
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus4.in_valid = 1'b0;
    rstn = 1'b1;

    // Scenario 2: 4x4 image, pixel(r,c)=r+1 -> one tile.
    p = 0; b = 0;
    while (p < 16 && b < 500) begin
      @(posedge clk); #1;
      bus4.in_valid = 1'b1;
      bus4.in_data  = 8'(p / 4 + 1);
      @(negedge clk);
      if (bus4.in_ready) p++;
      b++;
    end
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    check("s2_pixels", 128'(p), 128'(16));
    b = 0;
    @(negedge clk);
    while (!bus4.tile_valid && b < 50) begin @(negedge clk); b++; end
    check("s2_tile_valid", 128'(bus4.tile_valid), 128'(1));
    check("s2_tile_data", bus4.tile_data, 128'h01010101020202020303030304040404);
    check("s2_row_col", 128'({bus4.tile_row, bus4.tile_col}), '0);
    @(negedge clk);
    check("s2_frame_done", 128'(bus4.frame_done), 128'(1));
    check("s2_valid_drop", 128'(bus4.tile_valid), '0);
    @(negedge clk);
    check("s2_frame_done_pulse", 128'(bus4.frame_done), '0);

    // Scenario 3: 8x8, pixel=8r+c, ready held high.
    pat_add = 0; cap_en = 1;
    send_frame(0);
    wait_frames(1);
    cap_en = 0;
    check("s3_t00", got[0], 128'h00010203_08090a0b_10111213_18191a1b);
    check("s3_t01_head", 128'(got[1][127:96]), 128'h02030405);
    check("s3_t10_head", 128'(got[3][127:96]), 128'h10111213);
    check("s3_t22_tail", 128'(got[8][31:0]), 128'h3c3d3e3f);

    // Scenario 4: 5-cycle backpressure at tile (1,1).
    pat_add = 8'h40; stall_obs = 0;
    stall_at = 4; stall_len = 5; stall_req = 1;
    send_frame(0);
    wait_frames(2);
    check("s4_stall_cycles", 128'(stall_obs), 128'(5));

    // Scenario 5: ~50% in_valid duty.
    pat_add = 0; cap_en = 1;
    for (int i = 0; i < NT; i++) got[i] = '0;
    send_frame(1);
    wait_frames(3);
    cap_en = 0;
    check("s5_t00", got[0], 128'h00010203_08090a0b_10111213_18191a1b);
    check("s5_t22_tail", 128'(got[8][31:0]), 128'h3c3d3e3f);

    // Scenario 6: reset while holding tile (1,1).
    pat_add = 8'h20; abort = 0;
    stall_at = 4; stall_len = 30; stall_req = 1;
    fork send_frame(0); join_none
    #1;
    wait_flag("s6_stall_reached", 1'b1, 0);
    check("s6_at_tile11", 128'({bus8.tile_valid, bus8.tile_row, bus8.tile_col}),
          128'({1'b1, 8'd1, 8'd1}));
    @(posedge clk); #1 rstn = 1'b0;
    abort = 1;
    @(negedge clk);
    check("s6_reset_valid", 128'(bus8.tile_valid), '0);
    check("s6_reset_data", bus8.tile_data, '0);
    @(posedge clk); #1 rstn = 1'b1;
    wait_flag("s6_sender_stopped", 1'b0, 1);
    wait_flag("s6_stall_over", 1'b0, 0);
    abort = 0;
    pat_add = 5; cap_en = 1;
    send_frame(0);
    wait_frames(4);
    cap_en = 0;
    check("s6_fresh_t00", got[0], 128'h05060708_0d0e0f10_15161718_1d1e1f20);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
